// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It detects
//   load-use hazards and taken branches, sequences multi-cycle data-memory
//   accesses with a req/ack FSM (IDLE/WAIT with timeout abort), and keeps
//   saturating performance counters for memory stall cycles and load-use
//   bubbles.
//
// Parameters
//   TIMEOUT_CYC  max WAIT cycles per dmem access before abort (>=2)
//   CNT_W        width of the performance counters
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   id_rs1/id_rs2, *_used         source registers of the ID instruction
//   ex_rd, ex_memRead             destination / load flag of the EX instruction
//   ex_branch_taken               EX resolved a taken branch/jump
//   mem_memRead, mem_memWrite     MEM-stage load / store
//   dmem_ack                      data memory completes the access this cycle
//   dmem_req                      access request to data memory
//   stall_pc/if_id/id_ex/ex_mem   hold the corresponding pipeline register
//   flush_if_id, flush_id_ex      clear the corresponding register to a bubble
//   mem_timeout                   sticky flag: an access was aborted
//   stall_cnt, bubble_cnt         saturating performance counters
//
// All stall/flush/req outputs are combinational (same-cycle); only the FSM,
// wait counter, timeout flag and counters are registered.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_branch_taken,
  input  logic             mem_memRead,
  input  logic             mem_memWrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int WCNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state;
  logic [WCNT_W-1:0] waitCnt;
  logic              memTimeout;
  logic [CNT_W-1:0]  stallCnt;
  logic [CNT_W-1:0]  bubbleCnt;

  logic memOp;
  logic toutHit;
  logic memBusy;
  logic loadUse;
  logic bubbleIns;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign memOp   = mem_memRead | mem_memWrite;
  assign toutHit = (state == S_WAIT) && !dmem_ack && (waitCnt == WCNT_LAST);

  // The ack cycle and the abort cycle both release the pipe.
  assign memBusy = ((state == S_IDLE) && memOp && !dmem_ack) ||
                   ((state == S_WAIT) && !dmem_ack && !toutHit);

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign loadUse = ex_memRead && (ex_rd != 5'd0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd)) ||
                    (id_rs2_used && (id_rs2 == ex_rd)));

  // A bubble is only inserted when neither a memory stall nor a branch
  // flush takes precedence.
  assign bubbleIns = !memBusy && !ex_branch_taken && loadUse;

  always_comb begin
    dmem_req     = 1'b0;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    if (!reset) begin
      dmem_req = (state == S_WAIT) || memOp;
      if (memBusy) begin
        // Freeze the whole pipe; branch and load-use wait for release.
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
      end else if (ex_branch_taken) begin
        // Wrong-path instructions in IF/ID and ID/EX are squashed; this also
        // kills any load-use consumer.
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (loadUse) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      waitCnt    <= '0;
      memTimeout <= 1'b0;
      stallCnt   <= '0;
      bubbleCnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (memOp && !dmem_ack) begin
            state   <= S_WAIT;
            waitCnt <= '0;
          end
        end
        S_WAIT: begin
          if (dmem_ack) begin
            state <= S_IDLE;
          end else if (toutHit) begin
            state      <= S_IDLE;
            memTimeout <= 1'b1;
          end else begin
            waitCnt <= waitCnt + WCNT_W'(1);
          end
        end
      endcase
      if (memBusy) begin
        stallCnt <= satInc(stallCnt);
      end
      if (bubbleIns) begin
        bubbleCnt <= satInc(bubbleCnt);
      end
    end
  end

  assign mem_timeout = memTimeout;
  assign stall_cnt   = stallCnt;
  assign bubble_cnt  = bubbleCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl (TIMEOUT_CYC=4, CNT_W=4 so that
//   timeout and counter saturation are reachable quickly). Each test task
//   drives one cycle of inputs at a time and pushes the expected output
//   vector into a queue; a negedge monitor pops and compares it. Counters are
//   checked inline in the tasks.
//   Vector bit order: {dmem_req, stall_pc, stall_if_id, stall_id_ex,
//                      stall_ex_mem, flush_if_id, flush_id_ex, mem_timeout}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int TOUT = 4;
  localparam int CW   = 4;

  localparam logic [7:0] V_NONE = 8'b0000_0000;
  localparam logic [7:0] V_LU   = 8'b0110_0010;
  localparam logic [7:0] V_BR   = 8'b0000_0110;
  localparam logic [7:0] V_BUSY = 8'b1111_1000;
  localparam logic [7:0] V_REQ  = 8'b1000_0000;
  localparam logic [7:0] V_TMO  = 8'b0000_0001;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_rs1_used, id_rs2_used;
  logic          ex_memRead, ex_branch_taken;
  logic          mem_memRead, mem_memWrite, dmem_ack;
  logic          dmem_req, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic          flush_if_id, flush_id_ex, mem_timeout;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  typedef struct {
    logic [7:0] vec;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  pipe_hazard_ctrl #(.TIMEOUT_CYC(TOUT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_branch_taken(ex_branch_taken),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: compare outputs mid-cycle against the queued vector.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = {dmem_req, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
             flush_if_id, flush_id_ex, mem_timeout};
      checks++;
      if (act !== e.vec) begin
        failures++;
        $display("FAIL %s: outputs=%b expected=%b", e.name, act, e.vec);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic exmr, input logic br, input logic mr,
                        input logic mw, input logic ack);
    id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    ex_rd = rd; ex_memRead = exmr; ex_branch_taken = br;
    mem_memRead = mr; mem_memWrite = mw; dmem_ack = ack;
  endtask

  // Queue the expectation for the cycle just driven and advance one cycle.
  task automatic step(input logic [7:0] v, input string nm);
    exp_t e;
    e.vec  = v;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_in(5'd3, 5'd3, 1, 1, 5'd3, 1, 1, 1, 0, 0);
    step(V_NONE, "reset_outputs_forced");
    checks++;
    if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_counters: stall=%0d bubble=%0d expected 0/0", stall_cnt, bubble_cnt);
    end
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(V_NONE, "post_reset_idle");
  endtask

  task automatic test_load_use;
    set_in(5'd5, 5'd9, 1, 1, 5'd5, 1, 0, 0, 0, 0);
    step(V_LU, "lu_rs1");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(V_NONE, "lu_rs1_after");
    checks++;
    if (bubble_cnt !== 4'd1) begin
      failures++;
      $display("FAIL lu_bubble1: bubble=%0d expected 1", bubble_cnt);
    end
    set_in(5'd1, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0, 0);
    step(V_LU, "lu_rs2");
    set_in(5'd1, 5'd7, 1, 0, 5'd7, 1, 0, 0, 0, 0);
    step(V_NONE, "lu_rs2_unused");
    checks++;
    if (bubble_cnt !== 4'd2) begin
      failures++;
      $display("FAIL lu_bubble2: bubble=%0d expected 2", bubble_cnt);
    end
  endtask

  task automatic test_no_hazard;
    set_in(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 0);
    step(V_NONE, "x0_load");
    set_in(5'd6, 5'd0, 1, 0, 5'd6, 0, 0, 0, 0, 0);
    step(V_NONE, "match_not_load");
    checks++;
    if (bubble_cnt !== 4'd2) begin
      failures++;
      $display("FAIL nohaz_bubble: bubble=%0d expected 2", bubble_cnt);
    end
  endtask

  task automatic test_mem_ack;
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(V_BUSY, "ack_c1");
    step(V_BUSY, "ack_c2");
    step(V_BUSY, "ack_c3");
    dmem_ack = 1'b1;
    step(V_REQ, "ack_c4_release");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(V_REQ, "ack_immediate_store");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(V_NONE, "ack_idle");
    checks++;
    if (stall_cnt !== 4'd3) begin
      failures++;
      $display("FAIL ack_stall_cnt: stall=%0d expected 3", stall_cnt);
    end
  endtask

  task automatic test_timeout;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(V_BUSY, "tmo_idle");
    step(V_BUSY, "tmo_w0");
    step(V_BUSY, "tmo_w1");
    step(V_BUSY, "tmo_w2");
    step(V_REQ, "tmo_abort");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(V_TMO, "tmo_sticky");
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(V_REQ | V_TMO, "tmo_sticky_ack");
    checks++;
    if (stall_cnt !== 4'd7) begin
      failures++;
      $display("FAIL tmo_stall_cnt: stall=%0d expected 7", stall_cnt);
    end
  endtask

  task automatic test_priority;
    set_in(5'd4, 5'd0, 1, 0, 5'd4, 1, 1, 0, 0, 0);
    step(V_BR | V_TMO, "pri_branch_over_lu");
    set_in(5'd4, 5'd0, 1, 0, 5'd4, 1, 1, 1, 0, 0);
    step(V_BUSY | V_TMO, "pri_busy_over_all");
    dmem_ack = 1'b1;
    step(V_REQ | V_BR | V_TMO, "pri_release_branch");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(V_TMO, "pri_idle");
    checks++;
    if (bubble_cnt !== 4'd2 || stall_cnt !== 4'd8) begin
      failures++;
      $display("FAIL pri_counters: stall=%0d bubble=%0d expected 8/2", stall_cnt, bubble_cnt);
    end
  endtask

  task automatic test_reset_mid_wait;
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(V_BUSY | V_TMO, "rw_idle");
    step(V_BUSY | V_TMO, "rw_w0");
    step(V_BUSY | V_TMO, "rw_w1");
    reset = 1'b1;
    step(V_TMO, "rw_reset_cycle");
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(V_NONE, "rw_back_idle");
    checks++;
    if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
      failures++;
      $display("FAIL rw_counters: stall=%0d bubble=%0d expected 0/0", stall_cnt, bubble_cnt);
    end
  endtask

  // Repeated timed-out accesses with mem_op held high: restarts right after
  // each abort and drives stall_cnt into saturation.
  task automatic test_back_to_back;
    logic tmo;
    tmo = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int a = 0; a < 5; a++) begin
      for (int c = 0; c < TOUT; c++) step(V_BUSY | {7'd0, tmo}, "b2b_busy");
      step(V_REQ | {7'd0, tmo}, "b2b_abort");
      tmo = 1'b1;
      if (a == 2) begin
        checks++;
        if (stall_cnt !== 4'd12) begin
          failures++;
          $display("FAIL b2b_cnt12: stall=%0d expected 12", stall_cnt);
        end
      end
    end
    checks++;
    if (stall_cnt !== 4'd15) begin
      failures++;
      $display("FAIL b2b_stall_sat: stall=%0d expected 15", stall_cnt);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(V_TMO, "b2b_idle");
  endtask

  task automatic test_bubble_sat;
    set_in(5'd2, 5'd0, 1, 0, 5'd2, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(V_LU | V_TMO, "sat_lu");
    checks++;
    if (bubble_cnt !== 4'd15) begin
      failures++;
      $display("FAIL sat_bubble15: bubble=%0d expected 15", bubble_cnt);
    end
    step(V_LU | V_TMO, "sat_lu_extra");
    step(V_LU | V_TMO, "sat_lu_extra2");
    checks++;
    if (bubble_cnt !== 4'd15) begin
      failures++;
      $display("FAIL sat_bubble_hold: bubble=%0d expected 15", bubble_cnt);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(V_TMO, "sat_idle");
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_ack();
    test_timeout();
    test_priority();
    test_reset_mid_wait();
    test_back_to_back();
    test_bubble_sat();
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
